// File: rtl/mul_seq_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier.
// Holds the FSM state encoding, the default operand width and the counter width helper.
// Configuration macro used by the sequencer: MUL_EARLY_EXIT_EN.
package mul_seq_pkg;

    // Default operand/result width of the multiplier.
    localparam int MUL_DEFAULT_WIDTH = 8;

    // Iteration counter width for the default width.
    localparam int CNT_W = $clog2(MUL_DEFAULT_WIDTH);

    // Sequencer states.
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_FIN  = 2'd2
    } mul_state_e;

    // Counter width for an arbitrary operand width (at least 1 bit).
    function automatic int mul_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Purely combinational, zero latency.
// No flow control.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/mul_shift_add_step.sv
// One shift-add multiply iteration: conditionally adds mcand into acc, shifts operands.
// Purely combinational, zero latency.
// No flow control; the sequencer decides when the result is registered.
module mul_shift_add_step
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplr_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0] mplr_o
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] carry;

    // The partial product is the multiplicand gated by the current multiplier LSB.
    assign addend   = mcand_i & {WIDTH{mplr_i[0]}};
    assign carry[0] = 1'b0;

    // Ripple-carry row of full adders; the carry out of the top bit is discarded.
    genvar i;
    generate
        for (i = 0; i < WIDTH - 1; i++) begin : g_fa
            full_adder u_fa (
                .a    (acc_i[i]),
                .b    (addend[i]),
                .cin  (carry[i]),
                .sum  (acc_o[i]),
                .cout (carry[i+1])
            );
        end
    endgenerate

    // MSB only needs its sum bit since the product is kept mod 2^WIDTH.
    assign acc_o[WIDTH-1] = acc_i[WIDTH-1] ^ addend[WIDTH-1] ^ carry[WIDTH-1];

    assign mcand_o = mcand_i << 1;
    assign mplr_o  = mplr_i >> 1;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier reusing one adder row over up to WIDTH RUN cycles.
// Latency: START accepted at edge 0, DONE pulses in cycle WIDTH+1 (earlier with MUL_EARLY_EXIT_EN).
// Backpressure: BUSYWAIT stalls the CPU while a request is being accepted or is running.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             DONE,
    output logic             BUSYWAIT
);

    localparam int SEQ_CNT_W = mul_cnt_w(WIDTH);

    localparam logic [1:0] ST_IDLE = MS_IDLE;
    localparam logic [1:0] ST_RUN  = MS_RUN;
    localparam logic [1:0] ST_FIN  = MS_FIN;

    localparam logic [SEQ_CNT_W-1:0] CNT_LAST = SEQ_CNT_W'(WIDTH - 1);

    logic [1:0]           state_q,  state_d;
    logic [WIDTH-1:0]     acc_q,    acc_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplr_q,   mplr_d;
    logic [SEQ_CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic [WIDTH-1:0]     step_acc;
    logic [WIDTH-1:0]     step_mcand;
    logic [WIDTH-1:0]     step_mplr;
    logic                 can_accept;
    logic                 last_iter;

    mul_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .mplr_i  (mplr_q),
        .acc_o   (step_acc),
        .mcand_o (step_mcand),
        .mplr_o  (step_mplr)
    );

    // A new request is only taken when no operation is in flight.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_FIN);

    // Decide whether the iteration being executed this cycle is the final one.
    always_comb begin
        last_iter = (cnt_q == CNT_LAST);
`ifdef MUL_EARLY_EXIT_EN
        // No more set multiplier bits means the remaining iterations add nothing.
        last_iter = last_iter || (step_mplr == '0);
`endif
    end

    // Next-state logic: operand capture, iteration and result hand-back.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (START) begin
                    mcand_d = DATA1;
                    mplr_d  = DATA2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = step_acc;
                mcand_d = step_mcand;
                mplr_d  = step_mplr;
                cnt_d   = cnt_q + 1'b1;
                if (last_iter) begin
                    result_d = step_acc;
                    state_d  = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign RESULT   = result_q;
    assign DONE     = (state_q == ST_FIN);
    assign BUSYWAIT = (START && can_accept) || (state_q == ST_RUN);

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with directed multiply vectors.
// Latency expectations follow the build (MUL_EARLY_EXIT_EN or fixed WIDTH cycles).
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_mul_sequencer;

    localparam int W = 8;

    logic         CLK   = 1'b0;
    logic         RESET = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] DATA1 = '0;
    logic [W-1:0] DATA2 = '0;
    logic [W-1:0] RESULT;
    logic         DONE;
    logic         BUSYWAIT;

    int checks = 0;
    int errors = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .RESULT   (RESULT),
        .DONE     (DONE),
        .BUSYWAIT (BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Cycle (relative to the accept cycle 0) in which DONE is expected.
    function automatic int exp_lat(input logic [W-1:0] b);
        int h;
        h = 0;
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 0; i < W; i++) if (b[i]) h = i;
        return h + 2;
`else
        h = b[0];
        return W + 1 + (h - h);
`endif
    endfunction

    // One multiply with START pulsed in cycle 0; optionally toggles START during RUN.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input bit toggle);
        int lat;
        int first_done;
        int dones;
        int busy;
        logic [W-1:0] res_at_done;
        lat         = exp_lat(b);
        first_done  = -1;
        dones       = 0;
        busy        = 0;
        res_at_done = '0;
        @(posedge CLK); #1;
        START = 1'b1;
        DATA1 = a;
        DATA2 = b;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge CLK);
            if (BUSYWAIT) busy++;
            if (DONE) begin
                dones++;
                if (first_done < 0) begin
                    first_done  = c;
                    res_at_done = RESULT;
                end
            end
            @(posedge CLK); #1;
            START = toggle && (c + 1 < lat) && (((c + 1) % 2) == 1);
            DATA1 = W'($urandom);
            DATA2 = W'($urandom);
        end
        chk({tag, " done_cycle"}, first_done, lat);
        chk({tag, " result"}, {24'd0, res_at_done}, {24'd0, exp_res});
        chk({tag, " result_hold"}, {24'd0, RESULT}, {24'd0, exp_res});
        chk({tag, " busy_cycles"}, busy, lat);
        chk({tag, " done_pulses"}, dones, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1;
        int l2;
        int d1;
        int d2;
        int busy;
        int dones;
        logic [W-1:0] r1;
        logic [W-1:0] r2;

        // Reset state.
        #1;
        chk("reset result", {24'd0, RESULT}, 32'd0);
        chk("reset done", {31'd0, DONE}, 32'd0);
        chk("reset busywait", {31'd0, BUSYWAIT}, 32'd0);
        #20;
        @(posedge CLK); #1;
        RESET = 1'b1;

        // Basic products, including wrap-around and zero multiplier.
        run_op("3x2", 8'd3, 8'd2, 8'd6, 1'b0);
        run_op("255x255", 8'd255, 8'd255, 8'd1, 1'b0);
        run_op("12x12", 8'd12, 8'd12, 8'd144, 1'b0);
        run_op("7x5", 8'd7, 8'd5, 8'd35, 1'b0);
        run_op("200x0", 8'd200, 8'd0, 8'd0, 1'b0);
        // START toggled and operands changed during RUN.
        run_op("6x7 toggle", 8'd6, 8'd7, 8'd42, 1'b1);

        // Back-to-back: START held through FIN of 4*4 to accept 5*5.
        l1    = exp_lat(8'd4);
        l2    = exp_lat(8'd5);
        d1    = -1;
        d2    = -1;
        busy  = 0;
        dones = 0;
        r1    = '0;
        r2    = '0;
        @(posedge CLK); #1;
        START = 1'b1;
        DATA1 = 8'd4;
        DATA2 = 8'd4;
        for (int c = 0; c < l1 + l2 + 3; c++) begin
            @(negedge CLK);
            if (c < l1 + l2 && BUSYWAIT) busy++;
            if (DONE) begin
                dones++;
                if (d1 < 0) begin
                    d1 = c;
                    r1 = RESULT;
                end else if (d2 < 0) begin
                    d2 = c;
                    r2 = RESULT;
                end
            end
            @(posedge CLK); #1;
            DATA1 = 8'd5;
            DATA2 = 8'd5;
            START = (c + 1 <= l1);
        end
        chk("b2b first done_cycle", d1, l1);
        chk("b2b second done_cycle", d2, l1 + l2);
        chk("b2b first result", {24'd0, r1}, 32'd16);
        chk("b2b second result", {24'd0, r2}, 32'd25);
        chk("b2b busy_cycles", busy, l1 + l2);
        chk("b2b done_pulses", dones, 2);

        // Reset in cycle 4 of 9*9 aborts with no DONE.
        @(posedge CLK); #1;
        START = 1'b1;
        DATA1 = 8'd9;
        DATA2 = 8'd9;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK); #1;
            START = 1'b0;
        end
        RESET = 1'b0;
        #1;
        chk("abort result", {24'd0, RESULT}, 32'd0);
        chk("abort done", {31'd0, DONE}, 32'd0);
        chk("abort busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        dones = 0;
        busy  = 0;
        for (int c = 0; c < W + 4; c++) begin
            @(negedge CLK);
            if (DONE) dones++;
            if (BUSYWAIT) busy++;
        end
        chk("abort no_done", dones, 0);
        chk("abort stays_idle", busy, 0);
        run_op("2x3 after reset", 8'd2, 8'd3, 8'd6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
